music_sequencer: RTL
====================

# music_sequencer

Playback sequencer directly downstream of the music score RAM. It steps the score address, reads each key/duration pair, and holds the key on its output for the programmed number of beats. It detects the end-of-song terminator and reports completion. Its key output drives the tone generator; its address and read strobe drive the score RAM, which it only reads.

## Interface
- DataLength, 4, width of key and time fields
- AddressBits, 5, score address width
- SongLength, 12, maximum entries per song; address limit
- BeatDivider, 4, Clock cycles per time unit (beat); must be ≥1
- BeatCountBits, 24, beat counter width; must hold BeatDivider-1
- Clock  input  1  system clock, all state changes on rising edge
- Reset  input  1  asynchronous, active-low; 0 forces reset state immediately
- Start  input  1  level; begins playback from entry 0 when sampled high in IDLE
- Stop  input  1  level; aborts playback
- KeyIn  input  DataLength  key read from score RAM (registered there, 1-cycle read latency)
- TimeIn  input  DataLength  duration read from score RAM
- Address  output  AddressBits  score entry index
- ReadOrWrite  output  1  constant 1 (read); the block never writes the score
- Key  output  DataLength  current key to tone generator; 0 = silence
- Playing  output  1  high in FETCH, WAIT, PLAY
- Done  output  1  one-cycle pulse when a song ends normally

## Operation
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE: Key=0, Address=0. Start=1 and Stop=0 -> FETCH.
- FETCH: Address=index. -> WAIT unconditionally.
- WAIT: score RAM output is now valid; sample KeyIn/TimeIn at this edge.
  - KeyIn=0 and TimeIn=0: terminator -> IDLE, Done pulse, Key=0.
  - TimeIn=0 and KeyIn≠0: zero-length entry; skip. Key is unchanged; index+1 -> FETCH.
  - Otherwise: Key<=KeyIn. KeyIn=0 with TimeIn>0 is a rest. Load beats<=TimeIn, cycle count<=0 -> PLAY.
- PLAY: the cycle counter counts 0..BeatDivider-1. At wrap, beats decrements. When the wrap occurs with beats=1, the note ends:
  - index<SongLength-1: index+1 -> FETCH.
  - index=SongLength-1: end of song, same as terminator (Done pulse, -> IDLE).
- Key holds its previous value through FETCH/WAIT of the next entry. There is no silence gap between notes.
- Stop=1 in any state -> IDLE at the next edge. Key=0, Address=0, no Done pulse. Stop has priority over Start and over note completion.
- Start high during playback is ignored. If Start is held high after a song ends, a new song starts from IDLE on the next cycle.
- Index arithmetic is AddressBits wide and never exceeds SongLength-1. The RAM applies the song offset itself, so Address is relative.

## Timing
- Reset values: state IDLE, Address=0, Key=0, Playing=0, Done=0, counters 0. ReadOrWrite=1 always.
- Start sampled at edge 0 -> FETCH after edge 0 (Playing=1). WAIT after edge 1. Key valid after edge 2.
- Per-entry length is TimeIn×BeatDivider cycles in PLAY, plus 2 cycles in FETCH/WAIT.
- A skipped entry costs 2 cycles.
- Done is asserted for exactly the one cycle following the terminating edge, coincident with the IDLE entry.
- All outputs are registered. No combinational path from inputs to outputs.
- When Reset is deasserted, operation resumes at the next rising edge.

## Configuration
- MUSIC_SEQ_LOOP_EN defined: at end of song (terminator or index limit), index<=0 -> FETCH. The Done pulse is still issued and Playing stays 1. Only Stop or Reset exits.
- Undefined: end of song -> IDLE as described above.

## Test plan
- Reset mid-PLAY (Key=3) -> Key=0, Address=0, Playing=0 asynchronously. Normal start works after release.
- Score {3/1, 2/2, 0/0}, BeatDivider=4, Start pulse at edge 0:
  - Key=3 after edge 2, held 6 cycles.
  - Key=2 held 10 cycles.
  - Done pulse, then Key=0.
- Entry {1/0} between {2/1} and {3/1} -> Key goes 2 directly to 3 with 2 extra cycles; Key 1 never appears.
- Rest entry {0/2} -> Key=0 for 8 PLAY cycles, Playing stays 1.
- Twelve non-terminated entries -> after entry 11 Done pulses, Address returns 0, state IDLE. With MUSIC_SEQ_LOOP_EN, Address restarts at 0 and Playing stays 1.
- Stop and note end on the same edge -> IDLE, no Done, Address=0. Start asserted during PLAY has no effect on Address.

Source files
------------

// File: rtl/music_sequencer.sv
// Score playback sequencer: steps the score RAM address, holds each key for its beat count, reports song end.
// Optional MUSIC_SEQ_LOOP_EN: restart from entry 0 at end of song instead of returning to IDLE.
module music_sequencer #(
  parameter int DataLength    = 4,
  parameter int AddressBits   = 5,
  parameter int SongLength    = 12,
  parameter int BeatDivider   = 4,
  parameter int BeatCountBits = 24
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic [DataLength-1:0]  KeyIn,
  input  logic [DataLength-1:0]  TimeIn,
  output logic [AddressBits-1:0] Address,
  output logic                   ReadOrWrite,
  output logic [DataLength-1:0]  Key,
  output logic                   Playing,
  output logic                   Done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} stateType;

  localparam logic [AddressBits-1:0]   lastIndex = AddressBits'(SongLength - 1);
  localparam logic [BeatCountBits-1:0] lastCycle = BeatCountBits'(BeatDivider - 1);

  stateType                 state, nextState;
  logic [AddressBits-1:0]   index, nextIndex;
  logic [DataLength-1:0]    beats, nextBeats;
  logic [BeatCountBits-1:0] cycleCount, nextCycleCount;
  logic [AddressBits-1:0]   nextAddress;
  logic [DataLength-1:0]    nextKey;
  logic                     nextPlaying, nextDone;
  logic                     songEnd, terminator, loadKey;

  assign ReadOrWrite = 1'b1;

  // State and registered outputs; every output is a flop so nothing leaks combinationally from inputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      index      <= '0;
      beats      <= '0;
      cycleCount <= '0;
      Address    <= '0;
      Key        <= '0;
      Playing    <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= nextState;
      index      <= nextIndex;
      beats      <= nextBeats;
      cycleCount <= nextCycleCount;
      Address    <= nextAddress;
      Key        <= nextKey;
      Playing    <= nextPlaying;
      Done       <= nextDone;
    end
  end

  always_comb begin
    nextState      = state;
    nextIndex      = index;
    nextBeats      = beats;
    nextCycleCount = cycleCount;
    songEnd        = 1'b0;
    terminator     = 1'b0;
    loadKey        = 1'b0;
    if (Stop) begin
      nextState      = IDLE;
      nextIndex      = '0;
      nextBeats      = '0;
      nextCycleCount = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            nextState = FETCH;
            nextIndex = '0;
          end
        end
        FETCH: nextState = WAIT;
        WAIT: begin
          if (TimeIn == '0) begin
            // A zero-length note at the last slot has nowhere to advance to, so it ends the song.
            if (KeyIn == '0) begin
              terminator = 1'b1;
              songEnd    = 1'b1;
            end else if (index == lastIndex) begin
              songEnd = 1'b1;
            end else begin
              nextIndex = index + AddressBits'(1);
              nextState = FETCH;
            end
          end else begin
            loadKey        = 1'b1;
            nextBeats      = TimeIn;
            nextCycleCount = '0;
            nextState      = PLAY;
          end
        end
        PLAY: begin
          if (cycleCount == lastCycle) begin
            nextCycleCount = '0;
            nextBeats      = beats - DataLength'(1);
            if (beats == DataLength'(1)) begin
              if (index == lastIndex) begin
                songEnd = 1'b1;
              end else begin
                nextIndex = index + AddressBits'(1);
                nextState = FETCH;
              end
            end
          end else begin
            nextCycleCount = cycleCount + BeatCountBits'(1);
          end
        end
        default: nextState = IDLE;
      endcase
      if (songEnd) begin
`ifdef MUSIC_SEQ_LOOP_EN
        nextState = FETCH;
        nextIndex = '0;
`else
        nextState = IDLE;
        nextIndex = '0;
`endif
      end
    end
  end

  // Key carries over through FETCH/WAIT so consecutive notes join without a silence gap.
  always_comb begin
    nextKey     = Key;
    nextAddress = nextIndex;
    nextDone    = songEnd;
    nextPlaying = (nextState != IDLE);
    if (nextState == IDLE) begin
      nextKey     = '0;
      nextAddress = '0;
    end else if (loadKey) begin
      nextKey = KeyIn;
    end else if (terminator) begin
      nextKey = '0;
    end
  end

endmodule
